// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: one-entry holding register feeding a start/data/[parity]/stop serialiser.
// Define UART_TX_PARITY_EN to add the cfg_parity_odd input and a parity bit between data and stop.
//
// state  | meaning
// IDLE   | line idle (txd=1), waiting for a pulse with the holding register full
// START  | start bit (txd=0) on the line
// DATA   | data bit bit_cnt on the line, LSB first
// PARITY | parity bit on the line (UART_TX_PARITY_EN only)
// STOP   | stop bit on the line; stop_second marks the second of two
module uart_tx_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  input  logic              tx_baud_pulse,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              cfg_stop2,
`ifdef UART_TX_PARITY_EN
  input  logic              cfg_parity_odd,
`endif
  output logic              txd,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] ST_PARITY = 3'd3;
`endif
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic [2:0]        state;
  logic [DATA_W-1:0] hold;
  logic              hold_vld;
  logic [DATA_W-1:0] shift;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  bit_nxt;
  logic              stop2_q;
  logic              stop_second;
  logic              txd_q;
  logic              accept;
  logic              frame_end;
  logic              load;
`ifdef UART_TX_PARITY_EN
  logic              parity_odd_q;
  logic              par_bit;

  assign par_bit = (^shift) ^ parity_odd_q;
`endif

  assign bit_nxt = bit_cnt + CNT_W'(1);
  assign accept  = tx_valid && !hold_vld;

  // The last stop bit ends on this pulse unless a second stop bit is still owed.
  assign frame_end = tx_baud_pulse && (state == ST_STOP) && !(stop2_q && !stop_second);
  assign load      = hold_vld && ((tx_baud_pulse && (state == ST_IDLE)) || frame_end);

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      hold     <= '0;
      hold_vld <= 1'b0;
    end else if (load) begin
      hold_vld <= 1'b0;
    end else if (accept) begin
      hold     <= tx_data;
      hold_vld <= 1'b1;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state        <= ST_IDLE;
      shift        <= '0;
      bit_cnt      <= '0;
      stop2_q      <= 1'b0;
      stop_second  <= 1'b0;
      txd_q        <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_odd_q <= 1'b0;
`endif
    end else if (load) begin
      state        <= ST_START;
      shift        <= hold;
      bit_cnt      <= '0;
      stop2_q      <= cfg_stop2;
      stop_second  <= 1'b0;
      txd_q        <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_odd_q <= cfg_parity_odd;
`endif
    end else if (tx_baud_pulse) begin
      case (state)
        ST_IDLE: begin
          txd_q <= 1'b1;
        end
        ST_START: begin
          state   <= ST_DATA;
          bit_cnt <= '0;
          txd_q   <= shift[0];
        end
        ST_DATA: begin
          if (bit_cnt != LAST_BIT) begin
            bit_cnt <= bit_nxt;
            txd_q   <= shift[bit_nxt];
          end else begin
            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            state   <= ST_PARITY;
            txd_q   <= par_bit;
`else
            state       <= ST_STOP;
            stop_second <= 1'b0;
            txd_q       <= 1'b1;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          state       <= ST_STOP;
          stop_second <= 1'b0;
          txd_q       <= 1'b1;
        end
`endif
        ST_STOP: begin
          // Chaining into the next frame is handled by load above.
          if (stop2_q && !stop_second) begin
            stop_second <= 1'b1;
            txd_q       <= 1'b1;
          end else begin
            state <= ST_IDLE;
            txd_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          txd_q <= 1'b1;
        end
      endcase
    end
  end

  assign txd      = txd_q;
  assign tx_ready = !hold_vld;
  assign tx_busy  = (state != ST_IDLE) || hold_vld;
  assign tx_done  = frame_end;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Bench for uart_tx_ctrl: table-driven frames at a fixed baud divider, reset corner cases,
// and randomized pulses/handshakes checked against a bit-queue reference model.
module tb_uart_tx_ctrl;

  localparam int DIV = 16;

  logic       ACLK = 1'b0;
  logic       ARESETn;
  logic       tx_baud_pulse;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       cfg_stop2;
`ifdef UART_TX_PARITY_EN
  logic       cfg_parity_odd;
`endif
  logic       txd;
  logic       tx_busy;
  logic       tx_done;

  int n_vec = 0;
  int n_err = 0;
  int pcnt  = 0;

  uart_tx_ctrl #(.DATA_W(8)) dut (
    .ACLK          (ACLK),
    .ARESETn       (ARESETn),
    .tx_baud_pulse (tx_baud_pulse),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .cfg_stop2     (cfg_stop2),
`ifdef UART_TX_PARITY_EN
    .cfg_parity_odd(cfg_parity_odd),
`endif
    .txd           (txd),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done)
  );

  always #5 ACLK = ~ACLK;

  // Frame bits are listed left to right in transmission order, left-aligned in 24 bits.
  typedef struct {
    logic [7:0]  d0;
    logic [7:0]  d1;
    bit          two;
    bit          stop2;
    bit          flip;
    bit          odd;
    int          nbits;
    logic [23:0] bits;
    logic [23:0] done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [7:0] d0, logic [7:0] d1, bit two, bit stop2, bit flip,
                              bit odd, int nbits, logic [23:0] bits, logic [23:0] done);
    vec_t v;
    v.d0 = d0; v.d1 = d1; v.two = two; v.stop2 = stop2; v.flip = flip; v.odd = odd;
    v.nbits = nbits; v.bits = bits; v.done = done;
    return v;
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic next_cyc();
    @(negedge ACLK);
    tx_baud_pulse = (pcnt == DIV - 1);
    pcnt = (pcnt + 1) % DIV;
  endtask

  task automatic do_reset();
    ARESETn       = 1'b0;
    tx_valid      = 1'b0;
    tx_data       = 8'h00;
    tx_baud_pulse = 1'b0;
    cfg_stop2     = 1'b0;
`ifdef UART_TX_PARITY_EN
    cfg_parity_odd = 1'b0;
`endif
    pcnt = 0;
    repeat (3) @(negedge ACLK);
    ARESETn = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input string name);
    logic [7:0] q[$];
    bit started = 0;
    bit offered = 0;
    int idx = 0;
    int budget = 0;
    int k;
    q.push_back(v.d0);
    if (v.two) q.push_back(v.d1);
    cfg_stop2 = v.stop2;
`ifdef UART_TX_PARITY_EN
    cfg_parity_odd = v.odd;
`endif
    while (idx < v.nbits * DIV && budget < 60 * DIV) begin
      next_cyc();
      budget++;
      if (offered) void'(q.pop_front());
      offered = 0;
      if (q.size() > 0) begin
        tx_valid = 1'b1;
        tx_data  = q[0];
        offered  = tx_ready;
      end else begin
        tx_valid = 1'b0;
      end
      if (v.flip && started && idx == 3 * DIV) cfg_stop2 = !v.stop2;
      #1;
      if (!started && txd == 1'b0) started = 1;
      if (started) begin
        k = idx / DIV;
        chk($sformatf("%s txd bit%0d", name, k), txd, v.bits[23-k]);
        chk($sformatf("%s tx_done bit%0d", name, k), tx_done,
            v.done[23-k] && (idx % DIV == DIV - 1));
        idx++;
      end
    end
    tx_valid = 1'b0;
    if (idx < v.nbits * DIV) fail_now({name, " frame"});
    next_cyc();
    #1;
    chk({name, " idle txd"}, txd, 1'b1);
    chk({name, " idle busy"}, tx_busy, 1'b0);
    chk({name, " idle ready"}, tx_ready, 1'b1);
  endtask

  // Reference model: pending byte plus a queue of bits still to be sent in the current frame.
  logic       m_txd;
  bit         m_in_frame;
  bit         m_hold_vld;
  logic [7:0] m_hold;
  logic       m_rem[$];

  task automatic run_random(input int cycles);
    logic p, v, s2, exp_done;
    logic [7:0] d;
    bit pend;
`ifdef UART_TX_PARITY_EN
    logic od;
`endif
    m_txd = 1'b1; m_in_frame = 0; m_hold_vld = 0; m_hold = 8'h00; m_rem.delete();
    for (int c = 0; c < cycles; c++) begin
      @(negedge ACLK);
      p  = ($urandom_range(0, 3) == 0);
      v  = ($urandom_range(0, 2) == 0);
      d  = 8'($urandom);
      s2 = 1'($urandom_range(0, 1));
      tx_baud_pulse = p; tx_valid = v; tx_data = d; cfg_stop2 = s2;
`ifdef UART_TX_PARITY_EN
      od = 1'($urandom_range(0, 1));
      cfg_parity_odd = od;
`endif
      #1;
      exp_done = p && m_in_frame && (m_rem.size() == 0);
      chk("rand txd", txd, m_txd);
      chk("rand tx_ready", tx_ready, !m_hold_vld);
      chk("rand tx_busy", tx_busy, m_in_frame || m_hold_vld);
      chk("rand tx_done", tx_done, exp_done);
      pend = m_hold_vld;
      if (p) begin
        if (m_in_frame && m_rem.size() > 0) begin
          m_txd = m_rem.pop_front();
        end else if (m_hold_vld) begin
          for (int i = 0; i < 8; i++) m_rem.push_back(m_hold[i]);
`ifdef UART_TX_PARITY_EN
          m_rem.push_back((^m_hold) ^ od);
`endif
          m_rem.push_back(1'b1);
          if (s2) m_rem.push_back(1'b1);
          m_txd = 1'b0;
          m_in_frame = 1;
          m_hold_vld = 0;
        end else begin
          m_in_frame = 0;
          m_txd = 1'b1;
        end
      end
      if (v && !pend) begin
        m_hold = d;
        m_hold_vld = 1;
      end
    end
    tx_valid = 1'b0;
    tx_baud_pulse = 1'b0;
  endtask

  initial begin
    int cnt;
    bit seen;
    vec_t v5a;
`ifdef UART_TX_PARITY_EN
    tbl.push_back(mk(8'h07, 8'h00, 0, 0, 0, 0, 11, {11'b01110000011, 13'b0}, {11'b00000000001, 13'b0}));
    tbl.push_back(mk(8'h07, 8'h00, 0, 0, 0, 1, 11, {11'b01110000001, 13'b0}, {11'b00000000001, 13'b0}));
    tbl.push_back(mk(8'hA5, 8'h00, 0, 0, 0, 0, 11, {11'b01010010101, 13'b0}, {11'b00000000001, 13'b0}));
    v5a = mk(8'h5A, 8'h00, 0, 0, 0, 0, 11, {11'b00101101001, 13'b0}, {11'b00000000001, 13'b0});
`else
    tbl.push_back(mk(8'hA5, 8'h00, 0, 0, 0, 0, 10, {10'b0101001011, 14'b0}, {10'b0000000001, 14'b0}));
    tbl.push_back(mk(8'h00, 8'hFF, 1, 0, 0, 0, 20, {20'b0000000001_0111111111, 4'b0},
                     {20'b0000000001_0000000001, 4'b0}));
    tbl.push_back(mk(8'h3C, 8'h00, 0, 1, 1, 0, 11, {11'b00011110011, 13'b0}, {11'b00000000001, 13'b0}));
    tbl.push_back(mk(8'h96, 8'h00, 0, 0, 1, 0, 10, {10'b0011010011, 14'b0}, {10'b0000000001, 14'b0}));
    v5a = mk(8'h5A, 8'h00, 0, 0, 0, 0, 10, {10'b0010110101, 14'b0}, {10'b0000000001, 14'b0});
`endif

    ARESETn = 1'b0;
    tx_valid = 1'b0; tx_data = 8'h00; tx_baud_pulse = 1'b0; cfg_stop2 = 1'b0;
`ifdef UART_TX_PARITY_EN
    cfg_parity_odd = 1'b0;
`endif
    #12;
    chk("reset txd", txd, 1'b1);
    chk("reset tx_ready", tx_ready, 1'b1);
    chk("reset tx_busy", tx_busy, 1'b0);
    chk("reset tx_done", tx_done, 1'b0);
    do_reset();
    for (int i = 0; i < 3 * DIV; i++) begin
      next_cyc();
      #1;
      chk("post-reset txd", txd, 1'b1);
      chk("post-reset busy", tx_busy, 1'b0);
      chk("post-reset ready", tx_ready, 1'b1);
      chk("post-reset done", tx_done, 1'b0);
    end

    foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Async reset in the middle of data bit 3 of an all-zero byte.
    cfg_stop2 = 1'b0;
    next_cyc();
    tx_valid = 1'b1; tx_data = 8'h00;
    next_cyc();
    tx_valid = 1'b0;
    seen = 0;
    cnt = 0;
    for (int i = 0; i < 3 * DIV && !seen; i++) begin
      next_cyc();
      #1;
      if (txd == 1'b0) seen = 1;
    end
    if (!seen) fail_now("midreset start");
    else begin
      while (cnt < 4 * DIV + 7) begin
        next_cyc();
        cnt++;
      end
      #1;
      chk("midreset txd before", txd, 1'b0);
      #1;
      ARESETn = 1'b0;
      #1;
      chk("midreset txd async", txd, 1'b1);
      chk("midreset tx_ready", tx_ready, 1'b1);
      chk("midreset tx_busy", tx_busy, 1'b0);
      chk("midreset tx_done", tx_done, 1'b0);
      @(negedge ACLK);
      ARESETn = 1'b1;
      run_vec(v5a, "after-reset 5A");
    end

    do_reset();
    run_random(4000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
